// File: rtl/m1rstseq.sv
// Multi-channel reset sequencer: holds all channel resets until PLL lock is stable,
// then releases them in index order, with global restart and per-channel soft pulses.
module m1rstseq #(
    parameter int N_CH         = 4,
    parameter int CNT_W        = 20,
    parameter int HOLD_CYCLES  = 1024,
    parameter int STAGE_CYCLES = 16,
    parameter int PULSE_CYCLES = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    input  logic            pll_locked,
    input  logic            trigger_reset,
    input  logic [N_CH-1:0] ch_trigger,
    output logic [N_CH-1:0] rst_out_n,
    output logic            seq_busy,
    output logic            seq_done
);
    localparam int K_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {S_HOLD, S_RELEASE, S_RUN} state_t;

    state_t                  r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0]  r_sync;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
    logic [K_W-1:0]          r_k, w_k_nxt;
    logic [N_CH-1:0]         r_rel, w_rel_nxt;
    logic [N_CH-1:0][7:0]    r_pcnt, w_pcnt_nxt;
    logic [N_CH-1:0]         r_rst_out_n, w_rst_out_n_nxt;
    logic                    r_busy, r_done;
    logic                    w_lock_s, w_restart;

    assign w_lock_s  = r_sync[SYNC_STAGES-1];
    assign w_restart = !w_lock_s || trigger_reset;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_k_nxt         = r_k;
        w_rel_nxt       = r_rel;
        w_pcnt_nxt      = r_pcnt;
        w_rst_out_n_nxt = r_rst_out_n;

        if (w_restart) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = '0;
            w_k_nxt     = '0;
            w_rel_nxt   = '0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                        w_cnt_nxt   = '0;
                        w_k_nxt     = '0;
                        w_rel_nxt   = N_CH'(1);
                        w_state_nxt = (N_CH == 1) ? S_RUN : S_RELEASE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    if (r_cnt == CNT_W'(STAGE_CYCLES - 1)) begin
                        w_cnt_nxt = '0;
                        w_k_nxt   = r_k + K_W'(1);
                        for (int i = 0; i < N_CH; i++) begin
                            if (i == int'(r_k) + 1) w_rel_nxt[i] = 1'b1;
                        end
                        if (int'(r_k) == N_CH - 2) w_state_nxt = S_RUN;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                S_RUN:   w_cnt_nxt = '0;
                default: w_state_nxt = S_HOLD;
            endcase
        end

        // Soft pulses count down to zero; a request only takes on a channel already released
        for (int i = 0; i < N_CH; i++) begin
            if (w_restart) begin
                w_pcnt_nxt[i] = '0;
            end else if (ch_trigger[i] && r_rel[i]) begin
                w_pcnt_nxt[i] = 8'(PULSE_CYCLES);
            end else if (r_pcnt[i] != 8'd0) begin
                w_pcnt_nxt[i] = r_pcnt[i] - 8'd1;
            end else begin
                w_pcnt_nxt[i] = '0;
            end
            w_rst_out_n_nxt[i] = w_rel_nxt[i] && (w_pcnt_nxt[i] == 8'd0);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= S_HOLD;
            r_sync      <= '0;
            r_cnt       <= '0;
            r_k         <= '0;
            r_rel       <= '0;
            r_pcnt      <= '0;
            r_rst_out_n <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sync      <= {r_sync[SYNC_STAGES-2:0], pll_locked};
            r_cnt       <= w_cnt_nxt;
            r_k         <= w_k_nxt;
            r_rel       <= w_rel_nxt;
            r_pcnt      <= w_pcnt_nxt;
            r_rst_out_n <= w_rst_out_n_nxt;
            r_busy      <= (w_state_nxt != S_RUN);
            r_done      <= (w_state_nxt == S_RUN);
        end
    end

    assign rst_out_n = r_rst_out_n;
    assign seq_busy  = r_busy;
    assign seq_done  = r_done;
endmodule
